// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MEM_Signal bit positions, MEM-stage FSM states,
// default data-memory base address and the MEM/WB pipeline register layout.
package pipeline_pkg;

  localparam int MEM_R_BIT = 1;
  localparam int MEM_W_BIT = 0;

  localparam int unsigned ADDR_BASE_DEFAULT = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic        wb_en;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] ldata;
    logic        is_load;
  } memwb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the stage result every edge, or a bubble
// (all fields zero) while the stage is stalling.
module mem_wb_reg
  import pipeline_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   bubble_i,
  input  memwb_t d_i,
  output memwb_t q_o
);

  memwb_t memwb_d, memwb_q;

  always_comb begin
    memwb_d = d_i;
    if (bubble_i) memwb_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) memwb_q <= '0;
    else        memwb_q <= memwb_d;
  end

  assign q_o = memwb_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: issues loads and stores to a req/ready data
// memory, stalls upstream while an access is outstanding, drives register-file write-back.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_BASE = ADDR_BASE_DEFAULT,
  parameter int unsigned MEM_AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_En_EXE,
  input  logic [1:0]        MEM_Signal_EXE,
  input  logic [4:0]        dest_EXE,
  input  logic [31:0]       ALU_result_EXE,
  input  logic [31:0]       reg2_EXE,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              WB_En_WB,
  output logic [4:0]        WB_Dest_WB,
  output logic [31:0]       WB_Value,
  output logic              addr_err
);

  localparam logic [32:0] SPAN = 33'(64'd4 << MEM_AW);

  state_e state_q, state_d;
  logic   addr_err_q, addr_err_d;

  logic [32:0]       off;
  logic [MEM_AW-1:0] waddr;
  logic              is_rd, is_wr, mem_op, addr_bad, go;
  memwb_t            memwb_d, memwb_q;

  // 33-bit offset: an address below ADDR_BASE wraps to a huge value and fails the range test
  assign off      = {1'b0, ALU_result_EXE} - 33'(ADDR_BASE);
  assign addr_bad = (|off[1:0]) | (off >= SPAN);
  assign waddr    = off[MEM_AW+1:2];

  // 2'b11 decodes as a store
  assign is_wr  = MEM_Signal_EXE[MEM_W_BIT];
  assign is_rd  = MEM_Signal_EXE[MEM_R_BIT] & ~is_wr;
  assign mem_op = is_rd | is_wr;
  assign go     = mem_op & ~addr_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go)        state_d = BUSY;
      BUSY:    if (mem_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    if (state_q == BUSY) begin
      mem_req   = 1'b1;
      mem_we    = is_wr;
      mem_addr  = waddr;
      mem_wdata = reg2_EXE;
      stall     = ~mem_ready;
    end else begin
      stall = go;
    end
    // Nothing upstream may freeze on a stall raised while the pipeline is held in reset
    if (!rst) stall = 1'b0;
  end

  always_comb begin
    addr_err_d = addr_err_q;
    if (state_q == IDLE && mem_op && addr_bad) addr_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_err_q <= 1'b0;
    else      addr_err_q <= addr_err_d;
  end

  // A bad-address load completes in IDLE with load data 0
  always_comb begin
    memwb_d.wb_en   = WB_En_EXE & ~is_wr;
    memwb_d.dest    = dest_EXE;
    memwb_d.alu     = ALU_result_EXE;
    memwb_d.ldata   = (state_q == BUSY) ? mem_rdata : 32'd0;
    memwb_d.is_load = is_rd;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk      (clk),
    .rst_n    (rst),
    .bubble_i (stall),
    .d_i      (memwb_d),
    .q_o      (memwb_q)
  );

  assign WB_En_WB   = memwb_q.wb_en;
  assign WB_Dest_WB = memwb_q.dest;
  assign WB_Value   = memwb_q.is_load ? memwb_q.ldata : memwb_q.alu;
  assign addr_err   = addr_err_q;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the 5-stage pipeline. It consumes the EXE stage outputs and performs loads and stores against an external single-port data memory using a req/ready handshake, stalling the upstream pipeline while an access is outstanding. It registers the result into the MEM/WB pipeline register and drives the write-back enable, destination and data that the ID stage's register file consumes.

## Interface
Parameters:
- ADDR_BASE, 1024: byte address of data-memory word 0; subtracted from the ALU result before word indexing.
- MEM_AW, 8: word-address width of the data memory (256 words).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- WB_En_EXE  in  1  instruction writes back.
- MEM_Signal_EXE  in  2  bit1 = MEM_R_EN (load), bit0 = MEM_W_EN (store); 2'b11 is illegal.
- dest_EXE  in  5  destination register.
- ALU_result_EXE  in  32  result, or byte address for loads/stores.
- reg2_EXE  in  32  store data.
- stall  out  1  combinational; freezes IF/ID/EXE and their stage registers.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data; valid in the cycle mem_ready=1.
- mem_ready  in  1  access completes at this rising edge.
- WB_En_WB  out  1  register-file write enable to ID.
- WB_Dest_WB  out  5  write-back register.
- WB_Value  out  32  write-back data.
- addr_err  out  1  sticky flag for a bad-address access; cleared only by reset.

## Operation
- Word address: waddr = (ALU_result_EXE − ADDR_BASE) >> 2.
- An address is bad if its low 2 bits ≠ 0, or if (ALU_result_EXE − ADDR_BASE) is negative or ≥ 4·2^MEM_AW.
- FSM states:
  - IDLE. A load or store with a good address moves to BUSY. A bad-address op does not issue: it completes in IDLE, sets addr_err, loads read 0 and stores are dropped. Non-memory ops pass through.
  - BUSY. mem_req=1, with mem_we/mem_addr/mem_wdata driven from the held EXE inputs. A rising edge with mem_ready=1 completes the op, captures mem_rdata and returns to IDLE.
- stall = (IDLE ∧ good mem op) ∨ (BUSY ∧ ¬mem_ready).
- MEM/WB register, updated every edge:
  - stall=1: loads a bubble (WB_En 0).
  - otherwise: captures WB_En (forced 0 for stores), dest, ALU result, load data and an is_load bit.
- WB_Value = is_load ? load data : ALU result (combinational mux from registered fields).
- MEM_Signal_EXE=2'b11 is treated as a store; no assertion is required in RTL.

## Timing
- Non-memory op: 1 cycle, no stall; visible on WB_* the cycle after it is presented.
- Memory op: minimum 2 cycles, with 1 stall cycle when mem_ready is high in the first BUSY cycle. Each extra cycle mem_ready stays low adds one stall cycle.
- Upstream must hold EXE inputs stable while stall=1; the block does not latch them.
- mem_ready seen in IDLE is ignored.
- All outputs after reset: state IDLE, stall 0 (inputs are zero after reset), mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, WB_En_WB 0, WB_Dest_WB 0, WB_Value 0, addr_err 0.
- mem_* outputs are 0 whenever the block is not in BUSY.
- Reset asserted mid-BUSY aborts immediately: mem_req drops asynchronously and the pending op is lost.
- The memory must tolerate an abandoned request.

## Structure
- Shared package pipeline_pkg holds:
  - the MEM_Signal bit positions MEM_R_BIT=1 and MEM_W_BIT=0;
  - the state enum {IDLE, BUSY};
  - the ADDR_BASE default.
- Sub-module mem_wb_reg: the MEM/WB pipeline register, with bubble-load input and async active-low reset.
- FSM, address check and write-back mux live in the top of the block.
- A behavioural dmem_model with a configurable wait-state count lives in the bench only.

## Test plan
- ALU op, WB_En=1, dest=5, result=0x1234 → stall stays 0; the next cycle WB_En_WB=1, WB_Dest_WB=5, WB_Value=0x1234.
- Store reg2=0xDEADBEEF to 1032, 0 wait states → mem_req, mem_we=1, mem_addr=2 for 1 cycle; stall high 1 cycle; WB_En_WB stays 0.
- Load from 1032, 3 wait states, rdata=0xDEADBEEF, dest=7 → 4 stall cycles; exactly one WB_En_WB=1 pulse with WB_Dest_WB=7 and WB_Value=0xDEADBEEF; bubbles before it.
- Load from 1026 (misaligned), and separately from 1020 and 1024+1024 (out of range) → no mem_req, no stall; WB_Value=0; addr_err=1 and stays 1.
- Back-to-back load then ALU op → the ALU op is held by the stall and written back one cycle after the load, with no duplicate write-back.
- rst low during BUSY with mem_ready=0 → mem_req=0 and all outputs 0 immediately; after release, a new ALU op proceeds normally.
